// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Holds the FSM state encoding and the bit-counter width derivation.
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the serial subtractor.
// The requester drives start and operands; the controller returns status and result.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl_full_subtractor.sv
// One-bit full subtractor: diff = a - b - b_in, borrow_out when that underflows.
// This is the single shared datapath cell used by the serial controller.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic borrow_out
);
    assign diff       = a ^ b ^ b_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Start/busy/done handshake around a single shared full_subtractor cell.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;

    logic cell_diff;
    logic cell_bo;

    full_subtractor u_cell (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .b_in       (brw_q),
        .diff       (cell_diff),
        .borrow_out (cell_bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        case (state_q)
            RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 last.
                brw_d  = cell_bo;
                r_sh_d = (r_sh_q >> 1) | {cell_diff, {(WIDTH-1){1'b0}}};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    diff_d  = r_sh_d;
                    bo_d    = cell_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    brw_d   = bus.borrow_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl against an arithmetic model.
// Covers latency, held results, ignored starts, async reset and back-to-back ops.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;

    logic [W-1:0] prev_diff = '0;
    logic         prev_bo = 1'b0;

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bin);
        int unsigned d;
        logic [W-1:0] r;
        logic bo;
        d  = 32'(a) - 32'(b) - 32'(bin);
        r  = d[W-1:0];
        bo = (32'(a) < 32'(b) + 32'(bin));
        return {bo, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input bit junk, input string tag);
        logic [W:0] exp;
        int n;
        exp = model(a, b, bin);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.borrow_in = bin;
        step();
        bus.start = 1'b0;
        bus.a = $urandom();
        bus.b = $urandom();
        bus.borrow_in = 1'($urandom());
        check({tag, " busy_after_E0"}, 32'(bus.busy), 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.diff !== prev_diff || bus.borrow_out !== prev_bo)
                check({tag, " held"}, {23'd0, bus.borrow_out, bus.diff},
                      {23'd0, prev_bo, prev_diff});
            if (bus.busy !== 1'b1)
                check({tag, " busy_run"}, 32'(bus.busy), 1);
            if (junk && n == 2) begin
                bus.start = 1'b1;
                bus.a = 8'h00;
                bus.b = 8'hFF;
                bus.borrow_in = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            step();
            n++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(n), W);
        check({tag, " diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
        check({tag, " borrow"}, 32'(bus.borrow_out), 32'(exp[W]));
        check({tag, " busy_done"}, 32'(bus.busy), 1);
        prev_diff = exp[W-1:0];
        prev_bo = exp[W];
        step();
        check({tag, " done_1cyc"}, 32'(bus.done), 0);
        check({tag, " idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int dones;
        int last_done;
        int n;
        bit pd, ppd;
        logic [W:0] exp;

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.borrow_in = 1'b0;
        #12;
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst diff", 32'(bus.diff), 0);
        check("rst bo", 32'(bus.borrow_out), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        check("idle no start", 32'(bus.busy), 0);

        run_op(8'h05, 8'h03, 1'b0, 1'b0, "t5m3");
        run_op(8'h03, 8'h05, 1'b0, 1'b0, "t3m5");
        run_op(8'h00, 8'h00, 1'b1, 1'b0, "t0b1");
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "tFF");
        run_op(8'h10, 8'h01, 1'b0, 1'b1, "ignore");
        check("ignore stays idle", 32'(bus.busy), 0);

        // Async reset after four bits have been processed.
        bus.start = 1'b1;
        bus.a = 8'h5A;
        bus.b = 8'h33;
        bus.borrow_in = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        check("arst busy", 32'(bus.busy), 0);
        check("arst done", 32'(bus.done), 0);
        check("arst diff", 32'(bus.diff), 0);
        check("arst bo", 32'(bus.borrow_out), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_diff = '0;
        prev_bo = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) dones++;
        end
        check("arst no done", 32'(dones), 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 20; i++)
            run_op(W'($urandom()), W'($urandom()), 1'($urandom()), 1'b0, "rand");

        // Start held high: one op every W+2 cycles.
        exp = model(8'h37, 8'h12, 1'b0);
        bus.start = 1'b1;
        bus.a = 8'h37;
        bus.b = 8'h12;
        bus.borrow_in = 1'b0;
        dones = 0;
        last_done = -1;
        pd = 1'b0;
        ppd = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (pd) begin
                check("cont gap busy", 32'(bus.busy), 0);
                check("cont done width", 32'(bus.done), 0);
            end
            if (ppd) check("cont reaccept", 32'(bus.busy), 1);
            if (bus.done === 1'b1) begin
                dones++;
                check("cont diff", 32'(bus.diff), 32'(exp[W-1:0]));
                if (last_done >= 0)
                    check("cont period", 32'(i - last_done), W + 2);
                last_done = i;
            end
            ppd = pd;
            pd = (bus.done === 1'b1);
        end
        check("cont count", 32'(dones), 4);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check("cont drain", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
